// File: rtl/alu_wide_seq_pkg.sv
// Shared types for the 16-bit alu and the multi-word sequencer built on top of it.
package alu_wide_seq_pkg;

    typedef logic [15:0] AluVal;

    localparam int ALU_WORD_BITS = $bits(AluVal);

    typedef enum logic [2:0] {
        CMD_ADD   = 3'd0,
        CMD_AND   = 3'd1,
        CMD_OR    = 3'd2,
        CMD_XOR   = 3'd3,
        CMD_RSHFT = 3'd4
    } AluCmd;

    typedef struct packed {
        AluCmd cmd;
        logic  b_inv;          // invert d2 before the operation (subtract)
        logic  carry_disable;  // force the carry into the adder to zero
        logic  carry_in;       // adder carry, or bit shifted into the MSB
    } AluCtrl;

    typedef struct packed {
        AluCtrl ctrl;
        AluVal  d1;
        AluVal  d2;
    } AluArgs;

    typedef struct packed {
        AluVal res;
        logic  carry_out;
    } AluRet;

    // Wide operations; code 7 is unused and produces a zero result.
    typedef enum logic [2:0] {
        W_ADD   = 3'd0,
        W_SUB   = 3'd1,
        W_AND   = 3'd2,
        W_OR    = 3'd3,
        W_XOR   = 3'd4,
        W_RSHFT = 3'd5,
        W_CMP   = 3'd6
    } WideOp;

    // True for op codes that drive the alu; false for the unused code.
    function automatic logic is_known_op(input WideOp op);
        return op inside {W_ADD, W_SUB, W_AND, W_OR, W_XOR, W_RSHFT, W_CMP};
    endfunction

endpackage

// File: rtl/alu_wide_seq_alu.sv
// Existing single-word alu: purely combinational, one 16-bit operation per call.
module alu
    import alu_wide_seq_pkg::*;
(
    input  AluArgs args,
    output AluRet  ret
);

    AluVal b_eff;
    logic  cin_eff;

    assign b_eff   = args.ctrl.b_inv ? ~args.d2 : args.d2;
    assign cin_eff = args.ctrl.carry_disable ? 1'b0 : args.ctrl.carry_in;

    // Decode the command into a result word and carry out.
    always_comb begin
        ret = '0;
        case (args.ctrl.cmd)
            CMD_ADD: {ret.carry_out, ret.res} = {1'b0, args.d1} + {1'b0, b_eff}
                                                + {{ALU_WORD_BITS{1'b0}}, cin_eff};
            CMD_AND: ret.res = args.d1 & b_eff;
            CMD_OR:  ret.res = args.d1 | b_eff;
            CMD_XOR: ret.res = args.d1 ^ b_eff;
            CMD_RSHFT: begin
                // Logical right shift of d2; carry_in fills the MSB, LSB falls out.
                ret.res       = {cin_eff, args.d2[ALU_WORD_BITS-1:1]};
                ret.carry_out = args.d2[0];
            end
            default: ret = '0;
        endcase
    end

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-word sequencer: runs a WORDS x 16-bit operation through one alu, one word
// per cycle, chaining the carry, and returns the assembled result with flags.
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [2:0]                     req_op,
    input  logic [WORDS*ALU_WORD_BITS-1:0] req_a,
    input  logic [WORDS*ALU_WORD_BITS-1:0] req_b,
    input  logic                           req_cin,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WORDS*ALU_WORD_BITS-1:0] rsp_res,
    output logic                           rsp_carry,
    output logic                           rsp_zero
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state, next_state;

    // Latched request and working registers.
    AluVal [WORDS-1:0]  a_q;
    AluVal [WORDS-1:0]  b_q;
    AluVal [WORDS-1:0]  work_res;
    WideOp              op_q;
    logic               cin_q;
    logic [IDX_W-1:0]   idx;
    logic               c;        // carry from the previous word
    logic               nz_acc;   // any result word non-zero so far
    logic               rsp_valid_q;

    // Handshake / control strobes.
    logic               accept;
    logic               last_word;
    logic               publish;
    logic               rsp_fire;

    // Single alu instance and the per-word view of its result.
    AluArgs             alu_args;
    AluRet              alu_ret;
    AluVal              word_res;
    logic               word_carry;
    logic               op_known;

    alu u_alu (
        .args (alu_args),
        .ret  (alu_ret)
    );

    assign accept    = req_valid && req_ready;
    assign op_known  = is_known_op(op_q);
    assign last_word = (op_q == W_RSHFT) ? (idx == '0) : (idx == IDX_LAST);
    assign rsp_valid = rsp_valid_q;

    // The unused op code never lets the alu touch the result or carry.
    assign word_res   = op_known ? alu_ret.res       : '0;
    assign word_carry = op_known ? alu_ret.carry_out : 1'b0;

    // Build the alu arguments from the operand word selected by the index.
    always_comb begin
        alu_args         = '0;
        alu_args.d1      = a_q[idx];
        alu_args.d2      = b_q[idx];
        case (op_q)
            W_ADD: begin
                alu_args.ctrl.cmd      = CMD_ADD;
                alu_args.ctrl.carry_in = (idx == '0) ? cin_q : c;
            end
            W_SUB, W_CMP: begin
                // A - B as A + ~B + 1; the chained carry is the "no borrow" flag.
                alu_args.ctrl.cmd      = CMD_ADD;
                alu_args.ctrl.b_inv    = 1'b1;
                alu_args.ctrl.carry_in = (idx == '0) ? 1'b1 : c;
            end
            W_AND: begin
                alu_args.ctrl.cmd           = CMD_AND;
                alu_args.ctrl.carry_disable = 1'b1;
            end
            W_OR: begin
                alu_args.ctrl.cmd           = CMD_OR;
                alu_args.ctrl.carry_disable = 1'b1;
            end
            W_XOR: begin
                alu_args.ctrl.cmd           = CMD_XOR;
                alu_args.ctrl.carry_disable = 1'b1;
            end
            W_RSHFT: begin
                // Walk MSW first; each word takes bit 0 of the word above it.
                alu_args.ctrl.cmd      = CMD_RSHFT;
                alu_args.d1            = '0;
                alu_args.d2            = a_q[idx];
                alu_args.ctrl.carry_in = (idx == IDX_LAST) ? 1'b0 : a_q[idx + IDX_W'(1)][0];
            end
            default: alu_args = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= next_state;
        end
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        next_state = state;
        req_ready  = 1'b0;
        publish    = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = S_RUN;
            end
            S_RUN: begin
                if (last_word) next_state = S_DONE;
            end
            S_DONE: begin
                // First DONE cycle loads the response registers; later cycles wait.
                if (!rsp_valid_q) begin
                    publish = 1'b1;
                end else if (rsp_ready) begin
                    rsp_fire   = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand capture, word-by-word execution and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and result words are flops, not a RAM, so they are reset with the rest.
            a_q         <= '0;
            b_q         <= '0;
            work_res    <= '0;
            op_q        <= W_ADD;
            cin_q       <= 1'b0;
            idx         <= '0;
            c           <= 1'b0;
            nz_acc      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_res     <= '0;
            rsp_carry   <= 1'b0;
            rsp_zero    <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= req_a;
                b_q    <= req_b;
                op_q   <= WideOp'(req_op);
                cin_q  <= req_cin;
                idx    <= (WideOp'(req_op) == W_RSHFT) ? IDX_LAST : '0;
                c      <= 1'b0;
                nz_acc <= 1'b0;
            end

            if (state == S_RUN) begin
                work_res[idx] <= word_res;
                c             <= word_carry;
                nz_acc        <= nz_acc | (|word_res);
                if (!last_word) begin
                    idx <= (op_q == W_RSHFT) ? idx - IDX_W'(1) : idx + IDX_W'(1);
                end
            end

            // The last word's carry out is the final carry for every op
            // (logic ops and the unused code always leave it at zero).
            if (publish) begin
                rsp_valid_q <= 1'b1;
                rsp_res     <= work_res;
                rsp_carry   <= c;
                rsp_zero    <= !nz_acc;
            end else if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
